// File: rtl/if_pll_tuner_pkg.sv
// Shared definitions for the IF PLL tuner: FSM states, reconfig-core
// counter/parameter codes and tuning-word field positions.
package if_pll_tuner_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT_W,
    S_RECONFIG,
    S_WAIT_R,
    S_ARESET,
    S_WAIT_LOCK
  } state_t;

  localparam logic [3:0] CT_M  = 4'b0001;
  localparam logic [3:0] CT_C0 = 4'b0100;

  localparam logic [2:0] CP_HIGH   = 3'b000;
  localparam logic [2:0] CP_LOW    = 3'b001;
  localparam logic [2:0] CP_BYPASS = 3'b100;
  localparam logic [2:0] CP_ODD    = 3'b101;

  localparam int unsigned M_MSB  = 15;
  localparam int unsigned M_LSB  = 8;
  localparam int unsigned C0_MSB = 7;
  localparam int unsigned C0_LSB = 0;

endpackage

// File: rtl/if_pll_split.sv
// Splits a PLL counter value into the high/low/odd/bypass reconfig parameters.
module if_pll_split (
  input  logic [7:0] v,
  output logic [8:0] high,
  output logic [8:0] low,
  output logic [8:0] odd,
  output logic [8:0] bypass
);

  always_comb begin
    high   = ({1'b0, v} + 9'd1) >> 1;
    low    = {1'b0, v} >> 1;
    odd    = {8'd0, v[0]};
    bypass = {8'd0, (v == 8'd1)};
  end

endmodule

// File: rtl/if_pll_tuner.sv
// Retunes a PLL through its reconfig core: eight parameter writes, reconfig,
// areset pulse, then waits for lock. One-deep pending slot for late requests.
module if_pll_tuner
  import if_pll_tuner_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned BUSY_TIMEOUT  = 1023,
  parameter int unsigned ARESET_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] if_freq,
  input  logic        pll_freq_strobe,
  input  logic        busy,
  input  logic        pll_lock,
  output logic [3:0]  counter_type,
  output logic [2:0]  counter_param,
  output logic [8:0]  data_in,
  output logic        write_param,
  output logic        reconfig,
  output logic        pll_areset_in,
  output logic        locked,
  output logic        error,
  output logic        pending
);

  localparam int unsigned TMAX0 = (LOCK_TIMEOUT > BUSY_TIMEOUT) ? LOCK_TIMEOUT : BUSY_TIMEOUT;
  localparam int unsigned TMAX  = (TMAX0 > ARESET_CYCLES) ? TMAX0 : ARESET_CYCLES;
  localparam int unsigned TW    = $clog2(TMAX + 1);

  state_t        state, state_nxt;
  logic [7:0]    m_reg, c0_reg, m_nxt, c0_nxt, split_v;
  logic [15:0]   pend_freq, freq_src;
  logic [2:0]    idx, idx_nxt;
  logic [TW-1:0] tmo;
  logic          start, load_ctl, error_nxt;
  logic          first, busy_to, lock_to, areset_done;
  logic          lock_meta, lock_s;
  logic [8:0]    sp_high, sp_low, sp_odd, sp_bypass;

  // A queued request takes precedence over a fresh strobe when leaving IDLE.
  always_comb begin
    freq_src    = pending ? pend_freq : if_freq;
    start       = (state == S_IDLE) && (pending || pll_freq_strobe);
    m_nxt       = start ? freq_src[M_MSB:M_LSB] : m_reg;
    c0_nxt      = start ? freq_src[C0_MSB:C0_LSB] : c0_reg;
    first       = (tmo == '0);
    busy_to     = (tmo == TW'(BUSY_TIMEOUT - 1));
    lock_to     = (tmo == TW'(LOCK_TIMEOUT - 1));
    areset_done = (tmo == TW'(ARESET_CYCLES - 1));
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    error_nxt = error;
    load_ctl  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (m_nxt == '0 || c0_nxt == '0) begin
            error_nxt = 1'b1;
          end else begin
            state_nxt = S_WRITE;
            idx_nxt   = '0;
            load_ctl  = 1'b1;
          end
        end
      end
      S_WRITE: state_nxt = S_WAIT_W;
      S_WAIT_W: begin
        if (!first && !busy) begin
          if (idx == 3'd7) begin
            state_nxt = S_RECONFIG;
          end else begin
            state_nxt = S_WRITE;
            idx_nxt   = idx + 3'd1;
            load_ctl  = 1'b1;
          end
        end else if (busy_to) begin
          error_nxt = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_RECONFIG: state_nxt = S_WAIT_R;
      S_WAIT_R: begin
        if (!first && !busy) begin
          state_nxt = S_ARESET;
        end else if (busy_to) begin
          error_nxt = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_ARESET: if (areset_done) state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lock_s) begin
          error_nxt = 1'b0;
          state_nxt = S_IDLE;
        end else if (lock_to) begin
          error_nxt = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Split the value of the write about to be issued so the control outputs
  // are registered and valid for the whole WRITE cycle.
  assign split_v = idx_nxt[2] ? c0_nxt : m_nxt;

  if_pll_split u_split (
    .v      (split_v),
    .high   (sp_high),
    .low    (sp_low),
    .odd    (sp_odd),
    .bypass (sp_bypass)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      error         <= 1'b0;
      idx           <= '0;
      m_reg         <= '0;
      c0_reg        <= '0;
      tmo           <= '0;
      lock_meta     <= 1'b0;
      lock_s        <= 1'b0;
      pending       <= 1'b0;
      pend_freq     <= '0;
      counter_type  <= '0;
      counter_param <= '0;
      data_in       <= '0;
    end else begin
      state     <= state_nxt;
      error     <= error_nxt;
      idx       <= idx_nxt;
      m_reg     <= m_nxt;
      c0_reg    <= c0_nxt;
      tmo       <= (state_nxt != state || state == S_IDLE) ? '0 : tmo + TW'(1);
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      if (pll_freq_strobe && (state != S_IDLE || pending)) begin
        pending   <= 1'b1;
        pend_freq <= if_freq;
      end else if (state == S_IDLE && pending) begin
        pending <= 1'b0;
      end
      if (load_ctl) begin
        counter_type <= idx_nxt[2] ? CT_C0 : CT_M;
        case (idx_nxt[1:0])
          2'd0: begin counter_param <= CP_HIGH;   data_in <= sp_high;   end
          2'd1: begin counter_param <= CP_LOW;    data_in <= sp_low;    end
          2'd2: begin counter_param <= CP_BYPASS; data_in <= sp_bypass; end
          2'd3: begin counter_param <= CP_ODD;    data_in <= sp_odd;    end
        endcase
      end
    end
  end

  assign write_param   = (state == S_WRITE);
  assign reconfig      = (state == S_RECONFIG);
  assign pll_areset_in = (state == S_ARESET);
  assign locked        = (state == S_IDLE) && lock_s && !error;

endmodule

// File: tb/tb_if_pll_tuner.sv
// Directed scoreboard bench for if_pll_tuner with reconfig-busy and PLL-lock models.
module tb_if_pll_tuner;

  localparam int unsigned LT = 200;
  localparam int unsigned BT = 16;
  localparam int unsigned AC = 4;
  localparam int LOCK_DELAY  = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] if_freq = '0;
  logic        pll_freq_strobe = 1'b0;
  logic        busy = 1'b0;
  logic        pll_lock = 1'b0;
  logic [3:0]  counter_type;
  logic [2:0]  counter_param;
  logic [8:0]  data_in;
  logic        write_param, reconfig, pll_areset_in, locked, error, pending;

  always #10 clk = ~clk;

  if_pll_tuner #(
    .LOCK_TIMEOUT  (LT),
    .BUSY_TIMEOUT  (BT),
    .ARESET_CYCLES (AC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .if_freq         (if_freq),
    .pll_freq_strobe (pll_freq_strobe),
    .busy            (busy),
    .pll_lock        (pll_lock),
    .counter_type    (counter_type),
    .counter_param   (counter_param),
    .data_in         (data_in),
    .write_param     (write_param),
    .reconfig        (reconfig),
    .pll_areset_in   (pll_areset_in),
    .locked          (locked),
    .error           (error),
    .pending         (pending)
  );

  typedef struct packed {
    logic [3:0] ct;
    logic [2:0] cp;
    logic [8:0] d;
  } wr_t;

  wr_t sb[$];
  int  n_total = 0;
  int  n_pass  = 0;
  int  cyc = 0;
  int  wr_cnt = 0, rc_cnt = 0, ar_run = 0, ar_last = 0;
  int  t_ar_end = 0, t_err = 0, t_wr = 0;
  int  bcnt = 0, lcnt = 0;
  logic err_prev = 1'b0;
  logic busy_force = 1'b0;
  logic lock_enable = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc++;

  // Reconfig core: busy for 3 cycles after each write/reconfig pulse.
  always @(negedge clk) begin
    if (reset) bcnt = 0;
    else if (write_param || reconfig) bcnt = 3;
    else if (bcnt != 0) bcnt--;
    busy = busy_force || (bcnt != 0);
  end

  // PLL: loses lock on areset, regains it LOCK_DELAY cycles later if enabled.
  always @(negedge clk) begin
    if (pll_areset_in) begin
      pll_lock = 1'b0;
      lcnt = 0;
    end else if (lock_enable && lcnt < LOCK_DELAY) begin
      lcnt++;
      if (lcnt == LOCK_DELAY) pll_lock = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every write and records pulse timing.
  always @(negedge clk) begin
    if (write_param) begin
      wr_t w;
      wr_cnt++;
      t_wr = cyc;
      check("write_queued", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        w = sb.pop_front();
        check("write_word", 32'({counter_type, counter_param, data_in}), 32'(w));
      end
    end
    if (reconfig) rc_cnt++;
    if (pll_areset_in) ar_run++;
    else if (ar_run != 0) begin
      ar_last = ar_run;
      ar_run = 0;
      t_ar_end = cyc;
    end
    if (error && !err_prev) t_err = cyc;
    err_prev = error;
  end

  task automatic push_counter(input logic [3:0] ct, input int unsigned v);
    wr_t w;
    w.ct = ct;
    w.cp = 3'b000; w.d = 9'((v + 1) / 2); sb.push_back(w);
    w.cp = 3'b001; w.d = 9'(v / 2);       sb.push_back(w);
    w.cp = 3'b100; w.d = 9'(v == 1);      sb.push_back(w);
    w.cp = 3'b101; w.d = 9'(v % 2);       sb.push_back(w);
  endtask

  task automatic push_seq(input logic [15:0] f);
    push_counter(4'b0001, 32'(f[15:8]));
    push_counter(4'b0100, 32'(f[7:0]));
  endtask

  task automatic strobe(input logic [15:0] f);
    if_freq = f;
    pll_freq_strobe = 1'b1;
    @(negedge clk);
    pll_freq_strobe = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!(sb.size() == 0 && locked === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_error(input string tag, input int budget);
    int n = 0;
    while (error !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_write_param"}, 32'(write_param), 32'd0);
    check({tag, "_reconfig"}, 32'(reconfig), 32'd0);
    check({tag, "_areset"}, 32'(pll_areset_in), 32'd0);
    check({tag, "_counter_type"}, 32'(counter_type), 32'd0);
    check({tag, "_counter_param"}, 32'(counter_param), 32'd0);
    check({tag, "_data_in"}, 32'(data_in), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_pending"}, 32'(pending), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("rst");

    // Nominal retune 0x0C03: M=12, C0=3.
    wr_cnt = 0; rc_cnt = 0; ar_last = 0;
    push_seq(16'h0C03);
    strobe(16'h0C03);
    check("idle_strobe_not_pending", 32'(pending), 32'd0);
    wait_done("seq1_done", 1000);
    check("seq1_writes", 32'(wr_cnt), 32'd8);
    check("seq1_reconfig", 32'(rc_cnt), 32'd1);
    check("seq1_areset_len", 32'(ar_last), 32'(AC));
    check("seq1_error", 32'(error), 32'd0);
    check("seq1_locked", 32'(locked), 32'd1);
    check("hold_counter_type", 32'(counter_type), 32'h4);
    check("hold_counter_param", 32'(counter_param), 32'h5);
    check("hold_data_in", 32'(data_in), 32'h1);

    // Lock never returns: timeout measured from WAIT_LOCK entry.
    lock_enable = 1'b0;
    wr_cnt = 0;
    push_seq(16'h0C03);
    strobe(16'h0C03);
    wait_error("lock_to_seen", 1000);
    check("lock_to_delay", 32'(t_err - t_ar_end), 32'(LT));
    check("lock_to_locked", 32'(locked), 32'd0);
    check("lock_to_writes", 32'(wr_cnt), 32'd8);
    repeat (3) @(negedge clk);
    lock_enable = 1'b1;
    push_seq(16'h0C03);
    strobe(16'h0C03);
    wait_done("recover_done", 1000);
    check("recover_error_cleared", 32'(error), 32'd0);

    // Zero M: immediate error, no activity.
    wr_cnt = 0; rc_cnt = 0;
    strobe(16'h0005);
    check("zero_m_error", 32'(error), 32'd1);
    check("zero_m_locked", 32'(locked), 32'd0);
    check("zero_m_pending", 32'(pending), 32'd0);
    repeat (10) @(negedge clk);
    check("zero_m_writes", 32'(wr_cnt), 32'd0);
    check("zero_m_reconfig", 32'(rc_cnt), 32'd0);

    // Two late strobes: only the last one is queued.
    wr_cnt = 0; rc_cnt = 0;
    push_seq(16'h0C03);
    strobe(16'h0C03);
    repeat (5) @(negedge clk);
    strobe(16'h0A02);
    check("pending_set", 32'(pending), 32'd1);
    repeat (5) @(negedge clk);
    push_seq(16'h1404);
    strobe(16'h1404);
    check("pending_still_set", 32'(pending), 32'd1);
    wait_done("pending_done", 2000);
    check("pending_writes", 32'(wr_cnt), 32'd16);
    check("pending_reconfig", 32'(rc_cnt), 32'd2);
    check("pending_cleared", 32'(pending), 32'd0);
    check("pending_error", 32'(error), 32'd0);

    // Busy stuck high: timeout counted from WAIT_W entry.
    busy_force = 1'b1;
    repeat (2) @(negedge clk);
    wr_cnt = 0;
    sb.push_back(wr_t'({4'b0001, 3'b000, 9'd6}));
    strobe(16'h0C03);
    wait_error("busy_to_seen", 200);
    check("busy_to_delay", 32'(t_err - t_wr), 32'(BT + 1));
    check("busy_to_writes", 32'(wr_cnt), 32'd1);
    check("busy_to_locked", 32'(locked), 32'd0);
    busy_force = 1'b0;
    repeat (5) @(negedge clk);

    // Reset during the first WRITE cycle.
    wr_cnt = 0; rc_cnt = 0;
    sb.push_back(wr_t'({4'b0001, 3'b000, 9'd6}));
    strobe(16'h0C03);
    check("write_active_before_reset", 32'(write_param), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_writes", 32'(wr_cnt), 32'd1);
    check("midrst_reconfig", 32'(rc_cnt), 32'd0);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
